// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK command encodings and drive helper shared by the counter and its cells
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_e;

    // Forced set/reset drive toward a target bit; never toggles, so the result
    // does not depend on the cell's current state.
    function automatic jk_cmd_e jk_to_target(input logic tgt);
        return tgt ? JK_SET : JK_RST;
    endfunction

endpackage

// File: rtl/jk_sync_updown_counter_if.sv
// rtl/jk_sync_updown_counter_if.sv - control and status bundle for the JK up/down counter
interface jk_sync_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, up_dn, load, d,
        input  q, q_bar, tc, wrap, load_err
    );

    modport slave (
        input  en, up_dn, load, d,
        output q, q_bar, tc, wrap, load_err
    );
endinterface

// File: rtl/jk_ff_cell.sv
// rtl/jk_ff_cell.sv - rising-edge JK flip-flop with async active-low clear
module jk_ff_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            JK_HOLD: q_d = q_q;
            JK_RST:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;

endmodule

// File: rtl/jk_sync_updown_counter.sv
// rtl/jk_sync_updown_counter.sv - modulo-MOD up/down counter built from JK cells
module jk_sync_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    jk_sync_updown_counter_if.slave    bus
);

    localparam logic [WIDTH:0]   MOD_V = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qb_w;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] wrap_val;
    logic             d_over;
    logic             at_end;
    logic             tc_w;
    logic             carry;
    logic             wrap_q;
    logic             wrap_d;
    logic             load_err_q;
    logic             load_err_d;

    assign d_over   = ({1'b0, bus.d} >= MOD_V);
    assign load_val = d_over ? MAX_V : bus.d;
    assign at_end   = bus.up_dn ? (q_w == MAX_V) : (q_w == '0);
    assign tc_w     = bus.en & ~bus.load & at_end;
    assign wrap_val = bus.up_dn ? '0 : MAX_V;

    // Ripple the toggle condition: bit i flips only when every lower bit is
    // at the carry/borrow value for the current direction.
    always_comb begin
        j     = '0;
        k     = '0;
        carry = 1'b1;
        if (bus.load) begin
            for (int i = 0; i < WIDTH; i++) begin
                {j[i], k[i]} = jk_to_target(load_val[i]);
            end
        end else if (tc_w) begin
            for (int i = 0; i < WIDTH; i++) begin
                {j[i], k[i]} = jk_to_target(wrap_val[i]);
            end
        end else if (bus.en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (carry) begin
                    {j[i], k[i]} = JK_TGL;
                end
                carry = carry & (bus.up_dn ? q_w[i] : ~q_w[i]);
            end
        end
    end

    always_comb begin
        wrap_d     = tc_w;
        load_err_d = bus.load & d_over;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_ff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j[gi]),
            .k     (k[gi]),
            .q     (q_w[gi]),
            .q_bar (qb_w[gi])
        );
    end

    assign bus.q        = q_w;
    assign bus.q_bar    = qb_w;
    assign bus.tc       = tc_w;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;

endmodule

// File: doc/jk_sync_updown_counter.md
Name: jk_sync_updown_counter

Overview:
Synchronous modulo-N up/down counter built from per-bit JK flip-flop cells. The block consumes the JK flip-flop stage as its storage element. Per-bit J/K drive is derived from the count state, direction, enable and parallel load. It is the first multi-bit sequential block layered on the JK primitive and serves as a reusable divider/sequencer for later stages.

Parameters:
WIDTH, 4, counter width in bits.
MOD, 16, modulus; count range is 0..MOD-1; legal range 2..2**WIDTH.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  count enable.
up_dn  input  1  direction; 1 = up, 0 = down.
load  input  1  parallel load request.
d  input  WIDTH  parallel load value.
q  output  WIDTH  current count.
q_bar  output  WIDTH  bitwise complement of q at all times.
tc  output  1  terminal count (combinational).
wrap  output  1  registered one-cycle pulse after a wrap.
load_err  output  1  registered one-cycle pulse after an out-of-range load.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset: while rst_n=0, q=0, q_bar=all ones, wrap=0, load_err=0, independent of clk. Release takes effect on the first rising edge after rst_n rises.
- Reset asserted mid-count clears immediately. No pending load or wrap survives reset.
- Inputs are sampled on the rising edge. q reflects the new value after that edge, so latency is one cycle.
- Priority per edge is load > en > hold.
- Load:
  - If d < MOD: q <= d.
  - If d >= MOD: q <= MOD-1 and load_err=1 for the next cycle.
  - Load never asserts wrap.
  - Each bit i uses the JK set/reset command, not toggle: J=1,K=0 when the target bit is 1; J=0,K=1 when it is 0.
- Count up (en=1, up_dn=1):
  - If q != MOD-1: bit i toggles (J=K=1) when all lower bits of q are 1; otherwise it holds (J=K=0).
  - If q == MOD-1: q <= 0 using reset commands on all bits, and wrap=1 next cycle.
- Count down (en=1, up_dn=0):
  - If q != 0: bit i toggles when all lower bits of q are 0.
  - If q == 0: q <= MOD-1 using set/reset commands, and wrap=1 next cycle.
- Hold (en=0, load=0): all cells receive J=K=0, q is unchanged, and wrap and load_err are 0.
- tc = en & ~load & ((up_dn & q==MOD-1) | (~up_dn & q==0)). It is combinational and goes low whenever load is asserted.
- Changing direction in the same cycle as tc: the decision uses the up_dn value sampled at that edge. No extra-cycle hazard exists.
- When MOD = 2**WIDTH, the wrap path must give the same result as a natural toggle rollover, and wrap must still pulse.
- wrap and load_err are registered. Each is high for exactly one cycle per event, and back-to-back events give back-to-back pulses.
- q_bar is taken from the cells' complementary outputs. It must equal ~q in every cycle, including during reset.

Decomposition:
- Package jk_pkg holds:
  - JK command encodings JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
  - A function returning the {J,K} pair that drives a given current bit to a target bit.
- Sub-module jk_ff_cell, instantiated WIDTH times:
  - Ports: clk, rst_n, j, k, q, q_bar.
  - Rising-edge JK flip-flop with asynchronous active-low reset to q=0, q_bar=1.
  - The counter top contains only next-state J/K logic, the tc/wrap/load_err logic and the generate loop.

Test Plan:
1. WIDTH=4, MOD=10, en=1, up_dn=1 from reset for 12 cycles -> q = 1,2,...,9,0,1,2. tc high while q=9; wrap high the cycle q becomes 0.
2. MOD=10, up_dn=0 from reset -> q = 9,8,7. wrap pulses on the cycle q becomes 9. tc is high at q=0 and low at q=9.
3. MOD=10, q=4, load=1, d=7, en=1 -> q=7 next cycle with no count applied. Then d=12 -> q=9, load_err=1 for one cycle, wrap=0.
4. en=0 for 5 cycles at q=6 with up_dn toggling -> q stays 6, tc=0, q_bar=4'b1001 throughout.
5. WIDTH=4, MOD=16, q=15, up -> q=0 and wrap=1. Then set up_dn=0 at q=0 -> q=15 and wrap=1 on consecutive cycles.
6. Assert rst_n=0 asynchronously mid-cycle at q=5 -> q=0 and q_bar=4'b1111 before the next edge. After release, the first count edge gives q=1.
